// File: rtl/exp_table_pkg.sv
// Shared definitions for the exp-table write-stream receiver and its RAM banks.
// Table geometries for the ExpMu and ExpSigma producers, plus the receiver state encoding.
package exp_table_pkg;

  localparam int MU_ADDR_W    = 9;
  localparam int SIGMA_ADDR_W = 10;
  localparam int EXP_DATA_W   = 18;
  localparam int MU_DEPTH     = 512;
  localparam int SIGMA_DEPTH  = 588;  // x range -307..280

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Index width needed to address a table of the given depth (at least 1 bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/exp_table_bank.sv
// One exp-table RAM bank: simple dual port, synchronous write, registered read.
// Reads outside the table depth return zero; the writer only issues in-range addresses.
module exp_table_bank
  import exp_table_pkg::*;
#(
  parameter int ADDR_W = MU_ADDR_W,
  parameter int DATA_W = EXP_DATA_W,
  parameter int DEPTH  = MU_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int              IDX_W   = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_in_range;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_addr[IDX_W-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/exp_table_receiver.sv
// Receives one complete exp table into the write bank of a ping-pong RAM pair and
// serves the other bank to the MC cores; owns the bank-select bit and the fill checks.
module exp_table_receiver
  import exp_table_pkg::*;
#(
  parameter int ADDR_W = MU_ADDR_W,
  parameter int DATA_W = EXP_DATA_W,
  parameter int DEPTH  = MU_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done,
  input  logic              swap,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              valid,
  output logic              bank,
  output logic              error,
  output logic              drop_start
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n, cnt_inc;
  logic              bank_n, valid_n, error_n, drop_n;
  logic              in_range, wr_fire;
  logic              rd_sel;
  logic [DATA_W-1:0] q0, q1;

  assign in_range = {1'b0, wr_addr} < DEPTH_W;
  assign wr_fire  = (state == FILL) && wr_en && in_range;
  assign cnt_inc  = cnt + (ADDR_W + 1)'(wr_fire);
  assign ready    = (state == FULL);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bank_n  = bank;
    valid_n = valid;
    error_n = error;
    drop_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FILL;
          cnt_n   = '0;
          error_n = 1'b0;
        end
      end
      FILL: begin
        if (wr_en && !in_range) begin
          error_n = 1'b1;
        end
        // A restart wins over a completion arriving in the same cycle.
        if (start) begin
          cnt_n = '0;
        end else if (done) begin
          if (cnt_inc == DEPTH_W) begin
            state_n = FULL;
            cnt_n   = cnt_inc;
          end else begin
            state_n = IDLE;
            error_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      FULL: begin
        if (swap) begin
          bank_n  = ~bank;
          valid_n = 1'b1;
          if (start) begin
            state_n = FILL;
            cnt_n   = '0;
            error_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else if (start) begin
          drop_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bank       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      drop_start <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bank       <= bank_n;
      valid      <= valid_n;
      error      <= error_n;
      drop_start <= drop_n;
      rd_sel     <= bank;
    end
  end

  // Bank b is written only while it is the write bank, i.e. while bank != b.
  exp_table_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire && bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (q0)
  );

  exp_table_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire && !bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (q1)
  );

  // rd_sel is the bank value seen by the edge that loaded q0/q1.
  assign rd_data = rd_sel ? q1 : q0;

endmodule

// File: tb/tb_exp_table_receiver.sv
// Directed bench for exp_table_receiver: full fills, swaps, bad fills, FULL-state corner
// cases from a vector table, and asynchronous reset in the middle of a fill.
module tb_exp_table_receiver;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 512;

  logic              clk;
  logic              rst_n;
  logic              start, wr_en, done, swap;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              ready, valid, bank, error, drop_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic              swap;
    logic              exp_ready;
    logic              exp_valid;
    logic              exp_bank;
    logic              exp_error;
    logic              exp_drop;
  } vec_t;

  vec_t vecs[13];

  exp_table_receiver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .swap       (swap),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ready      (ready),
    .valid      (valid),
    .bank       (bank),
    .error      (error),
    .drop_start (drop_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic r, input logic v, input logic b,
                            input logic e, input logic d);
    check({tag, "_ready"}, 32'(ready), 32'(r));
    check({tag, "_valid"}, 32'(valid), 32'(v));
    check({tag, "_bank"},  32'(bank),  32'(b));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_drop"},  32'(drop_start), 32'(d));
  endtask

  // Writes n entries at addresses base.. with data = addr + offset.
  task automatic fill(input int n, input int base, input int offset, input bit do_start,
                      input bit done_last);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(base + i);
      wr_data = DATA_W'(base + i + offset);
      done    = done_last && (i == n - 1);
      tick();
    end
    wr_en = 1'b0;
    done  = 1'b0;
  endtask

  function automatic vec_t mk(input bit st, input bit we, input int addr, input int data,
                              input bit dn, input bit sw, input bit r, input bit v,
                              input bit b, input bit e, input bit d);
    vec_t x;
    x.start     = st;
    x.wr_en     = we;
    x.wr_addr   = ADDR_W'(addr);
    x.wr_data   = DATA_W'(data);
    x.done      = dn;
    x.swap      = sw;
    x.exp_ready = r;
    x.exp_valid = v;
    x.exp_bank  = b;
    x.exp_error = e;
    x.exp_drop  = d;
    return x;
  endfunction

  initial begin
    // Starts in FULL, read bank 0, error still set by an earlier out-of-range write.
    //              st we addr  data    dn sw  rdy val bnk err drp
    vecs[0]  = mk(1, 0,    0,      0, 0, 0,  1,  1,  0,  1,  1);  // start alone: dropped
    vecs[1]  = mk(0, 0,    0,      0, 0, 0,  1,  1,  0,  1,  0);  // drop lasts one cycle
    vecs[2]  = mk(0, 1,    5, 'h3ffff, 0, 0,  1,  1,  0,  1,  0);  // write ignored in FULL
    vecs[3]  = mk(0, 0,    0,      0, 1, 0,  1,  1,  0,  1,  0);  // done ignored in FULL
    vecs[4]  = mk(1, 0,    0,      0, 0, 1,  0,  1,  1,  0,  0);  // start+swap: swap and accept
    vecs[5]  = mk(0, 0,    0,      0, 0, 1,  0,  1,  1,  0,  0);  // swap in FILL ignored
    vecs[6]  = mk(0, 0,    0,      0, 1, 0,  0,  1,  1,  1,  0);  // done with count 0: bad fill
    vecs[7]  = mk(0, 0,    0,      0, 0, 1,  0,  1,  1,  1,  0);  // swap in IDLE ignored
    vecs[8]  = mk(1, 0,    0,      0, 0, 0,  0,  1,  1,  0,  0);  // accepted start clears error
    vecs[9]  = mk(1, 0,    0,      0, 0, 0,  0,  1,  1,  0,  0);  // restart in FILL: no drop
    vecs[10] = mk(0, 1,  600,      7, 0, 0,  0,  1,  1,  1,  0);  // out-of-range write
    vecs[11] = mk(1, 0,    0,      0, 0, 0,  0,  1,  1,  1,  0);  // restart keeps error
    vecs[12] = mk(0, 0,    0,      0, 1, 0,  0,  1,  1,  1,  0);  // done at count 0 again

    rst_n   = 1'b0;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    done    = 1'b0;
    swap    = 1'b0;
    rd_addr = '0;

    #12;
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;

    // First table, done on the last write.
    fill(DEPTH, 0, 0, 1, 1);
    check_outs("fill1", 1, 0, 0, 0, 0);

    swap    = 1'b1;
    rd_addr = ADDR_W'(37);
    tick();
    swap = 1'b0;
    check_outs("swap1", 0, 1, 1, 0, 0);
    tick();
    check("swap1_rd37", 32'(rd_data), 37);

    // Second table goes to bank 0 while cores keep reading bank 1.
    fill(256, 0, 1000, 1, 0);
    check("fill2_mid_rd37", 32'(rd_data), 37);
    fill(256, 256, 1000, 0, 1);
    check("fill2_end_rd37", 32'(rd_data), 37);
    check_outs("fill2", 1, 1, 1, 0, 0);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check_outs("swap2", 0, 1, 0, 0, 0);
    check("swap2_rd_old", 32'(rd_data), 37);
    tick();
    check("swap2_rd_new", 32'(rd_data), 1037);

    // Short fill: 511 writes, then done on its own.
    fill(DEPTH - 1, 0, 2000, 1, 0);
    check("short_ready_before_done", 32'(ready), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_outs("short_done", 0, 1, 0, 1, 0);
    // In IDLE, writes+done and swap are ignored.
    wr_en = 1'b1;
    done  = 1'b1;
    swap  = 1'b1;
    tick();
    wr_en = 1'b0;
    done  = 1'b0;
    swap  = 1'b0;
    check_outs("idle_ignore", 0, 1, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("restart_clears", 0, 1, 0, 0, 0);

    // Out-of-range write must neither write nor count.
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(600);
    wr_data = DATA_W'(99);
    tick();
    wr_en = 1'b0;
    check_outs("oor_write", 0, 1, 0, 1, 0);
    fill(DEPTH, 0, 3000, 0, 1);
    check_outs("oor_fill_full", 1, 1, 0, 1, 0);

    // FULL-state and control corner cases from the vector table.
    rd_addr = ADDR_W'(5);
    for (int i = 0; i < 13; i++) begin
      start   = vecs[i].start;
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      done    = vecs[i].done;
      swap    = vecs[i].swap;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                 vecs[i].exp_bank, vecs[i].exp_error, vecs[i].exp_drop);
    end
    start = 1'b0;
    wr_en = 1'b0;
    done  = 1'b0;
    swap  = 1'b0;
    check("full_bank_kept_rd5", 32'(rd_data), 3005);

    // Asynchronous reset after 200 writes of a new fill.
    fill(200, 0, 5000, 1, 0);
    rst_n = 1'b0;
    #2;
    check_outs("async_reset", 0, 0, 0, 0, 0);
    check("async_reset_rd_data", 32'(rd_data), 0);
    tick();
    rst_n = 1'b1;

    fill(DEPTH, 0, 4000, 1, 1);
    check_outs("post_reset_fill", 1, 0, 0, 0, 0);
    swap    = 1'b1;
    rd_addr = ADDR_W'(37);
    tick();
    swap = 1'b0;
    check_outs("post_reset_swap", 0, 1, 1, 0, 0);
    tick();
    check("post_reset_rd37", 32'(rd_data), 4037);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
